// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types, BCD limits and digit helpers for the countdown timer
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam int DEFAULT_TICK_DIV = 100000000;

  // Clamp out-of-range digits so the counter never starts from an illegal mm:ss.
  function automatic logic [15:0] sanitize_bcd(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (m1 > TENS_MAX) m1 = TENS_MAX;
    if (m0 > UNIT_MAX) m0 = UNIT_MAX;
    if (s1 > TENS_MAX) s1 = TENS_MAX;
    if (s0 > UNIT_MAX) s0 = UNIT_MAX;
    return {m1, m0, s1, s0};
  endfunction

  // mm:ss decrement; callers never pass 0000, so m1 needs no borrow.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = UNIT_MAX;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = TENS_MAX;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = UNIT_MAX;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - clock divider producing a one-cycle step enable every TICK_DIV enabled cycles
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max = (cnt == CNT_W'(TICK_DIV - 1));
  assign tick   = en & ~clr & at_max;

  // Count holds while disabled so a paused second resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_max ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - mm:ss countdown FSM with BCD decrementer; COUNTDOWN_BLINK_EN adds pause blinking
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int CNT_W    = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_pause,
  input  logic        clear,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        tick,
  output logic        blank
);

  state_t      state, next_state;
  logic [15:0] preset_s;
  logic [15:0] digits_dec;
  logic [15:0] digits_d;
  logic        tick_d;
  logic        step;
  logic        pre_en;
  logic        pre_clr;

  assign preset_s   = sanitize_bcd(preset);
  assign digits_dec = bcd_dec(digits);
  assign pre_en     = (state == RUN);
  assign pre_clr    = clear || (state == IDLE) || (state == DONE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (step)
  );

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_pause && preset_s != 16'h0000) next_state = RUN;
        // A final tick wins over a coincident pause request.
        RUN: begin
          if (step && digits_dec == 16'h0000) next_state = DONE;
          else if (start_pause)               next_state = PAUSE;
        end
        PAUSE:   if (start_pause) next_state = RUN;
        DONE:    if (start_pause) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    digits_d = digits;
    tick_d   = 1'b0;
    running  = (state == RUN);
    done     = (state == DONE);
    if (state == IDLE || next_state == IDLE) begin
      digits_d = preset_s;
    end else if (state == RUN && step) begin
      digits_d = digits_dec;
      tick_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      digits <= 16'h0000;
      tick   <= 1'b0;
    end else begin
      digits <= digits_d;
      tick   <= tick_d;
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  logic [CNT_W-1:0] half_cnt;
  logic             blank_q;

  // Restart the blink phase on every pause entry so the display is visible first.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      half_cnt <= '0;
      blank_q  <= 1'b0;
    end else if (next_state == PAUSE && state != PAUSE) begin
      half_cnt <= '0;
      blank_q  <= 1'b0;
    end else if (next_state == PAUSE) begin
      if (half_cnt == CNT_W'(TICK_DIV / 2 - 1)) begin
        half_cnt <= '0;
        blank_q  <= ~blank_q;
      end else begin
        half_cnt <= half_cnt + CNT_W'(1);
      end
    end else begin
      half_cnt <= '0;
      blank_q  <= 1'b0;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed self-checking bench for countdown_ctrl at TICK_DIV=4
module tb_countdown_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_pause = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] preset = 16'h0012;
  logic [15:0] digits;
  logic        running, done, tick, blank;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_seq [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                                16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
  logic        exp_blank;

  countdown_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_pause(start_pause),
    .clear      (clear),
    .preset     (preset),
    .digits     (digits),
    .running    (running),
    .done       (done),
    .tick       (tick),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sp();
    start_pause = 1'b1;
    step();
    start_pause = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    // Reset, then count 0012 down to 0000
    step();
    check("rst_digits", digits, 16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_tick", {15'd0, tick}, 16'd0);
    check("rst_blank", {15'd0, blank}, 16'd0);
    rst_n = 1'b0;
    step();
    check("idle_load", digits, 16'h0012);
    pulse_sp();
    check("start_running", {15'd0, running}, 16'd1);
    check("start_digits", digits, 16'h0012);
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check("no_tick", {15'd0, tick}, 16'd0);
      end
      step();
      check("tick", {15'd0, tick}, 16'd1);
      check("count", digits, exp_seq[k]);
      check("blank_run", {15'd0, blank}, 16'd0);
    end
    check("done_high", {15'd0, done}, 16'd1);
    check("done_not_running", {15'd0, running}, 16'd0);
    step(5);
    check("done_hold", {15'd0, done}, 16'd1);
    check("done_digits", digits, 16'h0000);
    pulse_sp();
    check("done_to_idle", {15'd0, done}, 16'd0);

    // Borrow chains
    preset = 16'h1000;
    step();
    pulse_sp();
    step(4);
    check("borrow_1000", digits, 16'h0959);
    pulse_clear();
    preset = 16'h0100;
    step();
    pulse_sp();
    step(4);
    check("borrow_0100", digits, 16'h0059);
    pulse_clear();

    // Pause two cycles after a tick, hold 20 cycles, resume
    preset = 16'h0030;
    step();
    pulse_sp();
    step(4);
    check("pre_pause", digits, 16'h0029);
    step();
    pulse_sp();
    check("pause_running", {15'd0, running}, 16'd0);
    check("pause_blank0", {15'd0, blank}, 16'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check("pause_digits", digits, 16'h0029);
      check("pause_tick", {15'd0, tick}, 16'd0);
`ifdef COUNTDOWN_BLINK_EN
      exp_blank = ((i / 2) % 2) == 1;
`else
      exp_blank = 1'b0;
`endif
      check("pause_blank", {15'd0, blank}, {15'd0, exp_blank});
    end
    pulse_sp();
    check("resume_running", {15'd0, running}, 16'd1);
    check("resume_blank", {15'd0, blank}, 16'd0);
    step();
    check("resume_no_tick", {15'd0, tick}, 16'd0);
    step();
    check("resume_tick", {15'd0, tick}, 16'd1);
    check("resume_digits", digits, 16'h0028);
    pulse_clear();

    // Zero and out-of-range presets
    preset = 16'h0000;
    step();
    pulse_sp();
    check("zero_idle", {15'd0, running}, 16'd0);
    check("zero_digits", digits, 16'h0000);
    preset = 16'h7A8F;
    step();
    check("sanitize", digits, 16'h5959);
    pulse_sp();
    check("sanitize_run", {15'd0, running}, 16'd1);
    step(4);
    check("sanitize_dec", digits, 16'h5958);

    // clear and start_pause together during RUN
    preset = 16'h0234;
    clear = 1'b1;
    start_pause = 1'b1;
    step();
    clear = 1'b0;
    start_pause = 1'b0;
    check("clr_sp_running", {15'd0, running}, 16'd0);
    check("clr_sp_digits", digits, 16'h0234);

    // Tick coinciding with start_pause away from zero: decrement then PAUSE
    preset = 16'h0005;
    step();
    pulse_sp();
    step(3);
    pulse_sp();
    check("tick_sp_tick", {15'd0, tick}, 16'd1);
    check("tick_sp_digits", digits, 16'h0004);
    check("tick_sp_pause", {14'd0, running, done}, 16'd0);
    pulse_clear();

    // Tick coinciding with start_pause at 0001: DONE wins
    preset = 16'h0001;
    step();
    pulse_sp();
    step(3);
    pulse_sp();
    check("last_tick_done", {15'd0, done}, 16'd1);
    check("last_tick_digits", digits, 16'h0000);
    step();
    check("last_tick_stay", {14'd0, running, done}, 16'd1);
    pulse_clear();

    // Reset mid-RUN
    preset = 16'h0012;
    step();
    pulse_sp();
    step(6);
    rst_n = 1'b1;
    step();
    check("midrst_digits", digits, 16'h0000);
    check("midrst_flags", {12'd0, running, done, tick, blank}, 16'd0);
    rst_n = 1'b0;
    step();
    check("midrst_idle", {14'd0, running, done}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Countdown timer controller for the lab 5 display path: sequences a programmable prescaler (clock divider) and a BCD mm:ss down-counter under start/pause/clear pulses. It sits between the debounced, one-pulsed push-button logic and the seven-segment scan/decoder. It owns the only divider in the timer path; no free-running 1 Hz clock is exported, and all logic runs on `clk` with a one-cycle enable `tick`.

## Interface
Parameters:
- `TICK_DIV`, 100000000 — `clk` cycles per countdown step (1 Hz at 100 MHz); must be ≥ 2 and even.
- `CNT_W`, 27 — prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- `clk`  in  1  global clock.
- `rst_n`  in  1  reset, synchronous, active-high; name kept for codebase consistency.
- `start_pause`  in  1  single-cycle pulse; start, pause or resume.
- `clear`  in  1  single-cycle pulse; abort and return to IDLE.
- `preset`  in  16  BCD {m1,m0,s1,s0}; start value.
- `digits`  out  16  BCD {m1,m0,s1,s0}; current display value.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `tick`  out  1  one-cycle pulse on each decrement.
- `blank`  out  1  display blank request (see Configuration).

## Operation
- Reset: state IDLE, prescaler 0, `digits`=0000, `running`=`done`=`tick`=`blank`=0.
- IDLE: `digits` loads the sanitised `preset` every cycle. A tens digit >5 becomes 5; a units digit >9 becomes 9. On `start_pause`: sanitised preset ≠ 0000 → RUN with prescaler cleared to 0; otherwise stay in IDLE.
- RUN: the prescaler counts 0..TICK_DIV-1 and wraps. At TICK_DIV-1, `tick`=1 and `digits` decrements.
  - BCD borrow chain: s0 0→9 borrows from s1; s1 0→5 borrows from m0; m0 0→9 borrows from m1.
  - A decrement that reaches 0000 → DONE.
  - `start_pause` → PAUSE.
- PAUSE: the prescaler holds its value, so the partial second is preserved. `start_pause` → RUN and counting resumes from the held count.
- DONE: `digits`=0000, `done`=1. Either `start_pause` or `clear` → IDLE.
- `clear` in any state → IDLE with prescaler 0.
- Priority:
  - `clear` beats `start_pause`.
  - In RUN, a tick coinciding with `start_pause` applies the decrement, then enters PAUSE.
  - If that decrement reaches 0000, DONE wins over PAUSE.
- `rst_n` mid-operation aborts immediately to reset values; no partial state survives.

## Timing
- All outputs are registered. State and outputs change on the edge that samples the input pulse (one-edge latency).
- First `tick` occurs TICK_DIV cycles after the edge that enters RUN.
- Step period is exactly TICK_DIV cycles while in RUN; time spent in PAUSE is excluded.
- `tick` and the new `digits` value appear on the same edge. `done` rises on the edge that writes 0000.
- `running` equals (state==RUN) with no extra delay.

## Configuration
- `COUNTDOWN_BLINK_EN` defined:
  - In PAUSE, `blank` toggles every TICK_DIV/2 cycles, driven by a separate half-period counter cleared on PAUSE entry.
  - `blank` starts at 0 on PAUSE entry and is forced to 0 in every other state.
- Undefined: no half-period counter is built, and `blank` is tied to 0.

## Structure
- Package `countdown_pkg`:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - BCD limit constants (UNIT_MAX=9, TENS_MAX=5);
  - default TICK_DIV.
- Sub-module `tick_prescaler`:
  - inputs `clk`, `rst_n`, `en`, `clr`; output `tick`; parameters TICK_DIV and CNT_W;
  - holds its count when `en`=0;
  - `clr` wins over `en`.
- The FSM, BCD decrementer and optional blink counter stay in `countdown_ctrl`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset with preset=0012, then `start_pause` → `running`=1; `tick` every 4 cycles; `digits` 0011, 0010, 0009 … 0000. `done`=1 and `running`=0 on the 12th tick.
- Borrow chain: preset=1000, run one tick → 0959; preset=0100, one tick → 0059.
- Pause/resume: `start_pause` 2 cycles after a tick, hold PAUSE 20 cycles, resume. The next tick arrives 2 cycles after resume and `digits` does not change during PAUSE.
- Invalid and zero presets: preset=0000 plus `start_pause` → stays IDLE, `running`=0. Preset=7A8F is shown as 5959 in IDLE and counts from 5959.
- Simultaneous events:
  - `clear` and `start_pause` in the same cycle during RUN → IDLE, `digits`=preset.
  - Tick and `start_pause` coincide at 0001 → DONE, not PAUSE.
- Reset and blink: `rst_n` asserted mid-RUN → all outputs 0 on the next edge. With `COUNTDOWN_BLINK_EN`, `blank` toggles every 2 cycles in PAUSE and is 0 in RUN.
